activation: RTL

ACTIVATION -- requirements
Module: activation

---
 rtl/activation.sv | 63 ++++++
 1 files changed

// File: rtl/activation.sv
// activation: two-stage valid/ready pipeline applying bypass/relu/leaky/clamp per lane
module activation #(
  parameter int NUM_WIDTH  = 16,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 cfg_mode,
  input  logic [NUM_WIDTH-1:0]       cfg_cap,
  input  logic [LANES*NUM_WIDTH-1:0] up_data,
  input  logic                       up_valid,
  output logic                       up_ready,
  output logic [LANES*NUM_WIDTH-1:0] dn_data,
  output logic                       dn_valid,
  input  logic                       dn_ready
);
  localparam int W = NUM_WIDTH;
  logic [LANES*W-1:0] d1, res;
  logic [1:0] m1;
  logic [W-1:0] c1;
  logic v1, v2, ld1, ld2;
  assign ld2 = !v2 || dn_ready;
  assign ld1 = !v1 || ld2;
  assign up_ready = ld1;
  assign dn_valid = v2;
  function automatic logic [W-1:0] act(input logic signed [W-1:0] x, input logic [1:0] m,
                                       input logic signed [W-1:0] c);
    logic signed [W-1:0] lk;
    lk = x >>> LEAK_SHIFT;
    return m == 2'd0 ? x :
           m == 2'd1 ? (x < 0 ? '0 : x) :
           m == 2'd2 ? (x < 0 ? lk : x) :
           (x < 0 || c < 0) ? '0 : (x > c ? c : x);
  endfunction
  // per-lane result from the stage-1 beat and the config captured with it
  always_comb begin
    res = '0;
    for (int i = 0; i < LANES; i++) res[i*W +: W] = act(d1[i*W +: W], m1, c1);
  end
  // stage 1 captures the beat plus its config; stage 2 captures the result
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      m1 <= '0;
      c1 <= '0;
      dn_data <= '0;
    end else begin
      if (ld1) begin
        v1 <= up_valid;
        d1 <= up_data;
        m1 <= cfg_mode;
        c1 <= cfg_cap;
      end
      if (ld2) begin
        v2 <= v1;
        dn_data <= res;
      end
    end
  end
endmodule
